// File: rtl/instr_decode_stage_if.sv
// instr_decode_stage_if: fetch-side and execute-side handshake bundle of the decode stage
interface instr_decode_stage_if #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 2,
   parameter int IMM_W  = 6
);
   localparam int INSTR_W = 4 + 2 * REG_AW + IMM_W;
   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] in_instr;
   logic               out_valid;
   logic               out_ready;
   logic [3:0]         out_opcode;
   logic [REG_AW-1:0]  out_rd;
   logic [REG_AW-1:0]  out_rs;
   logic [DATA_W-1:0]  out_imm;
   logic [2:0]         out_alu_op;
   logic               out_use_imm;
   logic               out_reg_we;
   logic               out_mem_rd;
   logic               out_mem_wr;
   logic               out_set_flags;
   logic               out_branch;
   logic [1:0]         out_mov_sel;
   logic               out_illegal;
   modport master (
      output in_valid, in_instr, out_ready,
      input  in_ready, out_valid, out_opcode, out_rd, out_rs, out_imm, out_alu_op,
             out_use_imm, out_reg_we, out_mem_rd, out_mem_wr, out_set_flags,
             out_branch, out_mov_sel, out_illegal
   );
   modport slave (
      input  in_valid, in_instr, out_ready,
      output in_ready, out_valid, out_opcode, out_rd, out_rs, out_imm, out_alu_op,
             out_use_imm, out_reg_we, out_mem_rd, out_mem_wr, out_set_flags,
             out_branch, out_mov_sel, out_illegal
   );
endinterface

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: splits instruction words and decodes control, with a 2-entry skid buffer
module instr_decode_stage #(
   parameter int          DATA_W = 8,
   parameter int          REG_AW = 2,
   parameter int          IMM_W  = 6,
   parameter logic [15:0] OPC_EN = 16'hFFFF,
   parameter int          CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   instr_decode_stage_if.slave  bus,
   output logic [CNT_W-1:0]     decode_cnt
);
   localparam int INSTR_W = 4 + 2 * REG_AW + IMM_W;
   typedef struct packed {
      logic [3:0]        opcode;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs;
      logic [DATA_W-1:0] imm;
      logic [2:0]        alu_op;
      logic              use_imm;
      logic              reg_we;
      logic              mem_rd;
      logic              mem_wr;
      logic              set_flags;
      logic              branch;
      logic [1:0]        mov_sel;
      logic              illegal;
   } bundle_t;
   bundle_t    dec, main_q, skid_q;
   logic       main_v, skid_v, acc, pop, legal;
   logic [3:0] op;
   assign op            = bus.in_instr[INSTR_W-1 -: 4];
   assign legal         = OPC_EN[op];
   assign acc           = bus.in_valid && !skid_v;
   assign pop           = main_v && bus.out_ready;
   assign bus.in_ready  = !skid_v;
   assign bus.out_valid = main_v;
   assign {bus.out_opcode, bus.out_rd, bus.out_rs, bus.out_imm, bus.out_alu_op,
           bus.out_use_imm, bus.out_reg_we, bus.out_mem_rd, bus.out_mem_wr,
           bus.out_set_flags, bus.out_branch, bus.out_mov_sel, bus.out_illegal} = main_q;
   // field split and opcode decode; a masked opcode keeps its fields but loses every enable
   always_comb begin
      dec           = '0;
      dec.opcode    = op;
      dec.rd        = bus.in_instr[INSTR_W-5 -: REG_AW];
      dec.rs        = bus.in_instr[IMM_W +: REG_AW];
      dec.imm       = DATA_W'($signed(bus.in_instr[IMM_W-1:0]));
      dec.illegal   = !legal;
      dec.alu_op    = !legal ? 3'd0 : op < 4'd4 ? op[3:1] : op < 4'd10 ? 3'(op - 4'd2) : op == 4'd12 ? 3'd1 : 3'd0;
      dec.reg_we    = legal && (op < 4'd11 || op > 4'd13);
      dec.use_imm   = legal && (op == 4'd1 || op == 4'd3 || op == 4'd10 || op == 4'd11 || op == 4'd13 || op == 4'd15);
      dec.mem_rd    = legal && op == 4'd10;
      dec.mem_wr    = legal && op == 4'd11;
      dec.set_flags = legal && op == 4'd12;
      dec.branch    = legal && op == 4'd13;
      dec.mov_sel   = !legal ? 2'd0 : op == 4'd14 ? 2'd1 : op == 4'd15 ? 2'd2 : 2'd0;
   end
   // output register refills from skid first (FIFO order); new words park in skid while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_v     <= 1'b0;
         skid_v     <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
         decode_cnt <= '0;
      end else begin
         if (pop) decode_cnt <= decode_cnt + CNT_W'(1);
         if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
         end else if (!main_v || bus.out_ready) begin
            main_v <= skid_v || acc;
            skid_v <= 1'b0;
            if (skid_v || acc) main_q <= skid_v ? skid_q : dec;
         end else if (acc) begin
            skid_v <= 1'b1;
            skid_q <= dec;
         end
      end
   end
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed vectors on two decode stages (full mask / 16'h7FFF mask, 2-bit counter)
module tb_instr_decode_stage;
   logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [13:0] in_instr = '0;
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;
   int          tests = 0, fails = 0;
   localparam logic [15:0] WE_M  = 16'hC7FF;
   localparam logic [15:0] IMM_M = 16'hAC0A;
   always #5 clk = ~clk;
   instr_decode_stage_if ia();
   instr_decode_stage_if ib();
   assign ia.in_valid = in_valid;
   assign ia.in_instr = in_instr;
   assign ia.out_ready = out_ready;
   assign ib.in_valid = in_valid;
   assign ib.in_instr = in_instr;
   assign ib.out_ready = out_ready;
   instr_decode_stage dut_a (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(ia), .decode_cnt(cnt_a));
   instr_decode_stage #(.OPC_EN(16'h7FFF), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(ib), .decode_cnt(cnt_b));
   logic [27:0] got_a, got_b;
   assign got_a = {ia.out_opcode, ia.out_rd, ia.out_rs, ia.out_imm, ia.out_alu_op, ia.out_use_imm, ia.out_reg_we,
                   ia.out_mem_rd, ia.out_mem_wr, ia.out_set_flags, ia.out_branch, ia.out_mov_sel, ia.out_illegal};
   assign got_b = {ib.out_opcode, ib.out_rd, ib.out_rs, ib.out_imm, ib.out_alu_op, ib.out_use_imm, ib.out_reg_we,
                   ib.out_mem_rd, ib.out_mem_wr, ib.out_set_flags, ib.out_branch, ib.out_mov_sel, ib.out_illegal};
   // expected bundle straight from the opcode table
   function automatic logic [27:0] ref_b(input logic [13:0] w, input logic [15:0] en);
      logic [3:0] op = w[13:10];
      int         alu_tab [16] = '{0, 0, 1, 1, 2, 3, 4, 5, 6, 7, 0, 0, 1, 0, 0, 0};
      logic       ok = en[op];
      logic [7:0] imm = {{2{w[5]}}, w[5:0]};
      logic [1:0] mv = !ok ? 2'd0 : op == 4'd14 ? 2'd1 : op == 4'd15 ? 2'd2 : 2'd0;
      return {op, w[9:8], w[7:6], imm, ok ? 3'(alu_tab[op]) : 3'd0, ok & IMM_M[op], ok & WE_M[op],
              ok && op == 4'd10, ok && op == 4'd11, ok && op == 4'd12, ok && op == 4'd13, mv, !ok};
   endfunction
   function automatic logic [13:0] mk(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [5:0] imm);
      return {op, rd, rs, imm};
   endfunction
   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // reference: a FIFO of accepted words, capacity 2, plus a handshake count
   logic [13:0] q[$];
   int          n_hs = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         n_hs = 0;
      end else begin
         automatic bit pop = q.size() > 0 && out_ready;
         automatic bit push = in_valid && q.size() < 2;
         if (pop) n_hs++;
         if (flush) q.delete();
         else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(in_instr);
         end
      end
   end
   // every cycle out of reset: handshake state, counters and the presented bundle
   always @(negedge clk) begin
      if (rst_n) begin
         cmp("a_state", {ia.in_ready, ia.out_valid, cnt_a}, {q.size() < 2, q.size() > 0, n_hs[15:0]});
         cmp("b_state", {ib.in_ready, ib.out_valid, cnt_b}, {q.size() < 2, q.size() > 0, n_hs[1:0]});
         if (q.size() > 0) begin
            cmp("a_bundle", got_a, ref_b(q[0], 16'hFFFF));
            cmp("b_bundle", got_b, ref_b(q[0], 16'h7FFF));
         end
      end
   end
   task automatic drive(input logic v, input logic [13:0] w, input logic r, input logic f);
      in_valid = v;
      in_instr = w;
      out_ready = r;
      flush = f;
      @(posedge clk);
      #2;
   endtask
   initial begin
      drive(0, '0, 0, 0);
      drive(0, '0, 0, 0);
      rst_n = 1'b1;
      drive(0, '0, 0, 0);
      cmp("rst_hs", {ia.in_ready, ia.out_valid}, 2'b10);
      cmp("rst_bundle", got_a, 0);
      cmp("rst_cnt", {cnt_a, cnt_b}, 0);
      drive(1, mk(4'd0, 2'd1, 2'd2, 6'd0), 1, 0);
      cmp("add_fields", {ia.out_valid, ia.out_alu_op, ia.out_reg_we, ia.out_rd, ia.out_rs}, {1'b1, 3'd0, 1'b1, 2'd1, 2'd2});
      drive(1, mk(4'd1, 2'd0, 2'd3, 6'b111110), 1, 0);
      cmp("add_cnt", cnt_a, 1);
      cmp("addi_imm", {ia.out_imm, ia.out_use_imm}, {8'hFE, 1'b1});
      drive(1, mk(4'd12, 2'd2, 2'd1, 6'd0), 1, 0);
      cmp("cmp_ctl", {ia.out_set_flags, ia.out_alu_op, ia.out_reg_we}, {1'b1, 3'd1, 1'b0});
      drive(1, mk(4'd15, 2'd3, 2'd0, 6'd5), 1, 0);
      cmp("mov2_illegal", {ib.out_illegal, ib.out_opcode, ib.out_imm}, {1'b1, 4'd15, 8'd5});
      cmp("mov2_en_off", {ib.out_use_imm, ib.out_reg_we, ib.out_mem_rd, ib.out_mem_wr, ib.out_set_flags, ib.out_branch, ib.out_mov_sel, ib.out_alu_op}, 0);
      cmp("mov2_legal", {ia.out_illegal, ia.out_mov_sel, ia.out_reg_we, ia.out_use_imm}, {1'b0, 2'd2, 1'b1, 1'b1});
      drive(0, '0, 1, 0);
      cmp("drain", {ia.out_valid, cnt_a}, {1'b0, 16'd4});
      drive(1, mk(4'd2, 2'd1, 2'd1, 6'd1), 0, 0);
      cmp("stall_a", {ia.in_ready, ia.out_opcode}, {1'b1, 4'd2});
      drive(1, mk(4'd6, 2'd2, 2'd3, 6'h20), 0, 0);
      cmp("stall_b", {ia.in_ready, ia.out_opcode}, {1'b0, 4'd2});
      drive(1, mk(4'd9, 2'd3, 2'd2, 6'd7), 0, 0);
      cmp("stall_c_refused", {ia.in_ready, ia.out_opcode}, {1'b0, 4'd2});
      drive(0, '0, 1, 0);
      cmp("release_b", {ia.in_ready, ia.out_opcode, ia.out_imm}, {1'b1, 4'd6, 8'hE0});
      drive(1, mk(4'd9, 2'd3, 2'd2, 6'd7), 1, 0);
      cmp("release_c", {ia.out_valid, ia.out_opcode}, {1'b1, 4'd9});
      drive(0, '0, 1, 0);
      cmp("order_cnt", {ia.out_valid, cnt_a}, {1'b0, 16'd7});
      drive(1, mk(4'd4, 2'd0, 2'd1, 6'd2), 0, 0);
      drive(1, mk(4'd5, 2'd1, 2'd0, 6'd3), 0, 0);
      cmp("flush_full", ia.in_ready, 0);
      drive(1, mk(4'd13, 2'd2, 2'd2, 6'd4), 0, 1);
      cmp("flush", {ia.out_valid, ia.in_ready, cnt_a}, {1'b0, 1'b1, 16'd7});
      drive(0, '0, 1, 0);
      cmp("flush_lost", {ia.out_valid, cnt_a}, {1'b0, 16'd7});
      drive(1, mk(4'd10, 2'd1, 2'd2, 6'h3F), 0, 0);
      drive(1, mk(4'd11, 2'd2, 2'd1, 6'h01), 0, 0);
      #1 rst_n = 1'b0;
      #1 cmp("async_rst", {ia.out_valid, ib.out_valid, ia.in_ready, cnt_a, cnt_b, got_a}, {1'b0, 1'b0, 1'b1, 16'd0, 2'd0, 28'd0});
      drive(0, '0, 0, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) drive(1, mk(4'(i * 3 + 3), 2'(i), 2'(3 - i), 6'(i * 13)), 1, 0);
      drive(0, '0, 1, 0);
      cmp("wrap_cnt", {cnt_a, cnt_b}, {16'd5, 2'd1});
      drive(0, '0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
